// File: rtl/sc_seq_pkg.sv
// Shared types and helpers for the SC network sequencer: FSM state encoding,
// maximal-length LFSR tap masks and the argmax comparison rule.
package sc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_DRAIN,
    ST_RESOLVE
  } seq_state_e;

  // Fibonacci taps for a shift-left register with feedback into bit 0.
  // The MSB is always tapped; the other bits select x^(W-1-j) terms.
  function automatic logic [15:0] lfsr_taps(input int width);
    logic [15:0] t;
    case (width)
      3:       t = 16'b101;
      4:       t = 16'b1001;
      5:       t = 16'b10010;
      6:       t = 16'b100001;
      7:       t = 16'b1000001;
      8:       t = 16'b10001110;
      9:       t = 16'b100001000;
      10:      t = 16'b1000000100;
      default: t = 16'h0000;
    endcase
    return t;
  endfunction

  // Strictly-greater so an ascending scan keeps the lowest index on ties.
  function automatic logic argmax_beats(input logic [31:0] cand, input logic [31:0] best);
    return cand > best;
  endfunction

endpackage

// File: rtl/sc_network_sequencer_lfsr.sv
// Maximal-length Fibonacci LFSR used to drive one layer's MUX select.
module sc_lfsr
  import sc_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int SEED  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  output logic [WIDTH-1:0] state
);

  localparam logic [WIDTH-1:0] TAPS   = WIDTH'(lfsr_taps(WIDTH));
  localparam logic [WIDTH-1:0] SEED_V = WIDTH'(SEED);

  logic [WIDTH-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = SEED_V;
    end else if (en) begin
      state_d = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SEED_V;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/sc_network_sequencer.sv
// Runs one SC inference pass: clear the network, stream LFSR selects for L
// cycles, count ones per output after the pipeline delay, then resolve argmax.
module sc_network_sequencer
  import sc_seq_pkg::*;
#(
  parameter int K1       = 7,
  parameter int K2       = 4,
  parameter int N2       = 4,
  parameter int LEN_W    = 8,
  parameter int PIPE_LAT = 1,
  parameter int SEED1    = 1,
  parameter int SEED2    = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        abort,
  input  logic [LEN_W-1:0]            len_cfg,
  output logic                        busy,
  output logic                        done,
  output logic                        net_reset,
  output logic [K1-1:0]               sel1,
  output logic [K2-1:0]               sel2,
  input  logic [N2-1:0]               net_dout,
  output logic [N2*(LEN_W+1)-1:0]     counts,
  output logic [$clog2(N2)-1:0]       class_out,
  output logic                        result_valid
);

  localparam int CW = LEN_W + 1;
  localparam int IW = $clog2(N2);

  seq_state_e          state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    run_cnt_q, run_cnt_d;
  logic [2:0]          drn_q, drn_d;
  logic                lfsr_load, lfsr_en, accept, finish, abort_hit;
  logic [PIPE_LAT-1:0] vld_q;
  logic [CW-1:0]       cnt_q [N2];
  logic [IW-1:0]       class_q, best_idx;
  logic [CW-1:0]       best_val;
  logic                done_q, rv_q;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    run_cnt_d = run_cnt_q;
    drn_d     = drn_q;
    lfsr_load = 1'b0;
    lfsr_en   = 1'b0;
    accept    = 1'b0;
    finish    = 1'b0;
    abort_hit = abort && (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_CLEAR;
          len_d     = len_cfg;
          lfsr_load = 1'b1;
          accept    = 1'b1;
        end
      end
      ST_CLEAR: begin
        state_d   = ST_RUN;
        run_cnt_d = '0;
      end
      ST_RUN: begin
        lfsr_en   = 1'b1;
        run_cnt_d = run_cnt_q + LEN_W'(1);
        if (run_cnt_q == len_q) begin
          state_d = ST_DRAIN;
          drn_d   = '0;
        end
      end
      ST_DRAIN: begin
        drn_d = drn_q + 3'd1;
        if (drn_q == 3'(PIPE_LAT - 1)) begin
          state_d = ST_RESOLVE;
        end
      end
      ST_RESOLVE: begin
        state_d = ST_IDLE;
        finish  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort freezes everything in place: no further select steps, no result.
    if (abort_hit) begin
      state_d = ST_IDLE;
      lfsr_en = 1'b0;
      finish  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      run_cnt_q <= '0;
      drn_q     <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      run_cnt_q <= run_cnt_d;
      drn_q     <= drn_d;
    end
  end

  always_comb begin
    best_idx = '0;
    best_val = cnt_q[0];
    for (int i = 1; i < N2; i++) begin
      if (argmax_beats(32'(cnt_q[i]), 32'(best_val))) begin
        best_idx = IW'(i);
        best_val = cnt_q[i];
      end
    end
  end

  // Sample-valid pipe tracks the select-to-output latency of the network.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q   <= '0;
      done_q  <= 1'b0;
      rv_q    <= 1'b0;
      class_q <= '0;
      for (int i = 0; i < N2; i++) cnt_q[i] <= '0;
    end else begin
      vld_q  <= abort_hit ? '0 : ((vld_q << 1) | PIPE_LAT'(state_q == ST_RUN));
      done_q <= finish;
      if (accept) begin
        rv_q <= 1'b0;
        for (int i = 0; i < N2; i++) cnt_q[i] <= '0;
      end else if (abort_hit) begin
        rv_q <= 1'b0;
      end else if (finish) begin
        rv_q    <= 1'b1;
        class_q <= best_idx;
      end else if (vld_q[PIPE_LAT-1]) begin
        for (int i = 0; i < N2; i++) cnt_q[i] <= cnt_q[i] + CW'(net_dout[i]);
      end
    end
  end

  for (genvar g = 0; g < N2; g++) begin : g_pack
    assign counts[g*CW +: CW] = cnt_q[g];
  end

  sc_lfsr #(.WIDTH(K1), .SEED(SEED1)) u_lfsr1 (
    .clk   (clk),
    .reset (reset),
    .load  (lfsr_load),
    .en    (lfsr_en),
    .state (sel1)
  );

  sc_lfsr #(.WIDTH(K2), .SEED(SEED2)) u_lfsr2 (
    .clk   (clk),
    .reset (reset),
    .load  (lfsr_load),
    .en    (lfsr_en),
    .state (sel2)
  );

  assign busy         = (state_q != ST_IDLE);
  assign net_reset    = (state_q == ST_CLEAR);
  assign done         = done_q;
  assign result_valid = rv_q;
  assign class_out    = class_q;

endmodule

// File: tb/tb_sc_network_sequencer.sv
// Randomized bench for sc_network_sequencer against a cycle-timeline reference model.
module tb_sc_network_sequencer;

  localparam int K1 = 7, K2 = 4, N2 = 4, LEN_W = 8, P = 1, SEED1 = 1, SEED2 = 1;
  localparam int CW = LEN_W + 1;
  localparam int HN = 4096;

  logic              clk = 1'b0;
  logic              reset, start, abort;
  logic [LEN_W-1:0]  len_cfg;
  logic              busy, done, net_reset;
  logic [K1-1:0]     sel1;
  logic [K2-1:0]     sel2;
  logic [N2-1:0]     net_dout;
  logic [N2*CW-1:0]  counts;
  logic [1:0]        class_out;
  logic              result_valid;

  always #5 clk = ~clk;

  sc_network_sequencer #(
    .K1(K1), .K2(K2), .N2(N2), .LEN_W(LEN_W), .PIPE_LAT(P), .SEED1(SEED1), .SEED2(SEED2)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .len_cfg(len_cfg),
    .busy(busy), .done(done), .net_reset(net_reset), .sel1(sel1), .sel2(sel2),
    .net_dout(net_dout), .counts(counts), .class_out(class_out), .result_valid(result_valid)
  );

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  logic [N2-1:0] hist [0:HN-1];

  bit m_run = 0, m_rv = 0, m_rst_chk = 0, m_abt_chk = 0, m_busy_now = 0, chk_on = 0;
  int m_t = 0, m_L = 0, m_abt_c = 0;
  int dmode = 0, pbase = 0;
  logic [N2-1:0] dconst = '0;
  int pn [N2];
  int q1[$], q2[$];

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int exp_count(input int cls, input int lo, input int hi);
    int s = 0;
    for (int c = lo; c <= hi; c++)
      if (c >= 0 && c < HN) s += int'(hist[c][cls]);
    return s;
  endfunction

  // Maximal-length sequence: starts at seed, never zero, no repeat within a period.
  function automatic bit seq_ok(input int q[$], input int period, input int seed, input int len);
    bit ok = (q.size() == len);
    if (q.size() == 0) return 1'b0;
    if (q[0] != seed) ok = 1'b0;
    for (int k = 0; k < q.size(); k++) begin
      if (q[k] == 0) ok = 1'b0;
      if (k >= period && q[k] != q[k-period]) ok = 1'b0;
      for (int j = 1; j < period && j <= k; j++)
        if (q[k] == q[k-j]) ok = 1'b0;
    end
    return ok;
  endfunction

  task automatic check_cycle();
    int c;
    bit exp_done;
    int e [N2];
    int best, hi;
    c = cyc;
    exp_done = 1'b0;
    if (m_run && c == m_t + 3 + m_L + P) begin
      exp_done = 1'b1;
      for (int i = 0; i < N2; i++) begin
        e[i] = exp_count(i, m_t + 2 + P, m_t + 1 + P + m_L);
        chk_eq($sformatf("count%0d", i), counts[i*CW +: CW], e[i]);
      end
      best = 0;
      for (int i = 1; i < N2; i++) if (e[i] > e[best]) best = i;
      chk_eq("class_out", class_out, best);
      chk_eq("sel1_seq", seq_ok(q1, 127, SEED1, m_L), 1);
      chk_eq("sel2_seq", seq_ok(q2, 15, SEED2, m_L), 1);
      m_run = 1'b0;
      m_rv  = 1'b1;
    end
    m_busy_now = m_run && (c <= m_t + 2 + m_L + P);
    chk_eq("busy", busy, m_busy_now);
    chk_eq("net_reset", net_reset, m_run && (c == m_t + 1));
    chk_eq("done", done, exp_done);
    chk_eq("result_valid", result_valid, m_rv);
    if (m_run && c >= m_t + 2 && c <= m_t + 1 + m_L) begin
      q1.push_back(int'(sel1));
      q2.push_back(int'(sel2));
    end
    if (m_abt_chk) begin
      hi = (m_t + 1 + P + m_L < m_abt_c - 1) ? (m_t + 1 + P + m_L) : (m_abt_c - 1);
      for (int i = 0; i < N2; i++)
        chk_eq($sformatf("abort_count%0d", i), counts[i*CW +: CW], exp_count(i, m_t + 2 + P, hi));
      m_abt_chk = 1'b0;
    end
    if (m_rst_chk) begin
      chk_eq("reset_counts", counts, 0);
      chk_eq("reset_class", class_out, 0);
      chk_eq("reset_sel1", sel1, SEED1);
      chk_eq("reset_sel2", sel2, SEED2);
      m_rst_chk = 1'b0;
    end
  endtask

  task automatic step(input bit st, input bit ab, input bit rs, input int len);
    if (chk_on) check_cycle();
    start   = st;
    abort   = ab;
    reset   = rs;
    len_cfg = LEN_W'(len);
    case (dmode)
      0:       net_dout = N2'($urandom);
      1:       net_dout = dconst;
      default: for (int i = 0; i < N2; i++)
                 net_dout[i] = ((cyc - pbase) >= 0) && ((cyc - pbase) < pn[i]);
    endcase
    if (cyc < HN) hist[cyc] = net_dout;
    if (rs) begin
      m_run = 1'b0; m_rv = 1'b0; m_rst_chk = 1'b1; m_abt_chk = 1'b0;
    end else if (!m_busy_now && st) begin
      m_run = 1'b1; m_t = cyc; m_L = len + 1; m_rv = 1'b0;
      q1.delete(); q2.delete();
    end else if (m_busy_now && ab) begin
      m_run = 1'b0; m_rv = 1'b0; m_abt_chk = 1'b1; m_abt_c = cyc;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic finish_pass();
    int g = 0;
    while (m_run && g < 2000) begin
      step(0, 0, 0, $urandom_range(0, 255));
      g++;
    end
    if (m_run) chk_eq("pass_timeout", 0, 1);
    step(0, 0, 0, 0);
  endtask

  task automatic run_pass(input int len);
    step(1, 0, 0, len);
    finish_pass();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; len_cfg = '0; net_dout = '0;
    @(posedge clk); #1;
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    chk_on = 1'b1;
    repeat (3) step(0, 0, 0, 0);

    // All outputs firing, L=4: tie on every class resolves to class 0.
    dmode = 1; dconst = 4'b1111;
    run_pass(3);
    for (int i = 0; i < N2; i++) chk_eq("t1_count", counts[i*CW +: CW], 4);
    chk_eq("t1_class", class_out, 0);
    chk_eq("t1_valid", result_valid, 1);

    // Longest pass: count 256 must fit without saturation.
    dconst = 4'b0100;
    run_pass(255);
    chk_eq("t2_count2", counts[2*CW +: CW], 256);
    chk_eq("t2_count0", counts[0*CW +: CW], 0);
    chk_eq("t2_class", class_out, 2);

    // One full sel2 period.
    dmode = 0;
    run_pass(14);

    // Restart attempt mid-RUN with a different length is ignored.
    step(1, 0, 0, 9);
    repeat (4) step(0, 0, 0, 0);
    step(1, 0, 0, 3);
    finish_pass();

    // Abort on the third RUN cycle, then abort while idle, then a clean pass.
    step(1, 0, 0, 9);
    repeat (3) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    repeat (2) step(0, 0, 0, 0);
    run_pass(5);

    // Start and abort together in IDLE: start wins.
    step(1, 1, 0, 4);
    finish_pass();

    // Reset during DRAIN (L=6 -> DRAIN at t+8).
    step(1, 0, 0, 5);
    repeat (7) step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    repeat (6) step(0, 0, 0, 0);

    // Class firing profile 10/30/30/5 over 64 samples.
    dmode = 2;
    pn[0] = 10; pn[1] = 30; pn[2] = 30; pn[3] = 5;
    pbase = cyc + 2 + P;
    run_pass(63);
    chk_eq("t6_count0", counts[0*CW +: CW], 10);
    chk_eq("t6_count1", counts[1*CW +: CW], 30);
    chk_eq("t6_count2", counts[2*CW +: CW], 30);
    chk_eq("t6_count3", counts[3*CW +: CW], 5);
    chk_eq("t6_class", class_out, 1);

    // Single-sample pass and random-length passes.
    dmode = 0;
    run_pass(0);
    repeat (8) begin
      run_pass($urandom_range(0, 40));
      repeat ($urandom_range(0, 3)) step(0, 0, 0, 0);
    end
    repeat (3) step(0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sc_network_sequencer.md
Name: sc_network_sequencer

Overview:
Sequences one stochastic-computing inference pass of the two-layer SC MUX network (sc_mnist_network).
- On start: clears the network, then drives the layer-1 and layer-2 MUX selects from two reseeded LFSRs for a programmable stream length.
- Counts the ones on each network output bit and resolves the winning class by argmax.
- Sits between the host/testbench control interface and the network datapath.

Parameters:
K1, 7, layer-1 select width (network's K1)
K2, 4, layer-2 select width (network's K2)
N2, 4, number of network outputs / classes
LEN_W, 8, width of len_cfg; stream length L = len_cfg+1, range 1..2^LEN_W
PIPE_LAT, 1, cycles from a select being driven to the matching net_dout bit; legal 1..4
SEED1, 1, nonzero reset/restart seed of the sel1 LFSR
SEED2, 1, nonzero reset/restart seed of the sel2 LFSR

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  request an inference pass; accepted only in IDLE
abort  in  1  synchronous cancel of a pass in progress
len_cfg  in  LEN_W  stream length minus one; latched when start is accepted
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when results update
net_reset  out  1  reset to the network; high only in CLEAR
sel1  out  K1  layer-1 MUX select (network's K1-bit select port)
sel2  out  K2  layer-2 MUX select (network's K2-bit select port)
net_dout  in  N2  network output bitstreams
counts  out  N2*(LEN_W+1)  packed per-output one-counts; class i at bits [i*(LEN_W+1) +: LEN_W+1]
class_out  out  $clog2(N2)  argmax index
result_valid  out  1  counts/class_out hold a completed pass

Behaviour:
- Reset: state=IDLE; busy=0, done=0, net_reset=0, counts=0, class_out=0, result_valid=0; LFSR1=SEED1, LFSR2=SEED2; sel1/sel2 show the LFSR states.
- FSM states: IDLE, CLEAR, RUN, DRAIN, RESOLVE.
  - IDLE: on start=1, go to CLEAR; latch L=len_cfg+1; zero counts; clear result_valid; reload both LFSRs with their seeds.
  - CLEAR: 1 cycle; net_reset=1. Go to RUN.
  - RUN: exactly L cycles. Each cycle both LFSRs advance; the first RUN cycle drives the seed values. Go to DRAIN after L cycles.
  - DRAIN: exactly PIPE_LAT cycles. LFSRs hold.
  - RESOLVE: 1 cycle; register argmax of counts into class_out. Go to IDLE.
- On the first IDLE cycle after RESOLVE: done=1 and result_valid=1.
  - result_valid stays high until the next accepted start, abort, or reset.
- Sampling:
  - A PIPE_LAT-deep valid shift register is loaded with 1 in each RUN cycle and 0 otherwise.
  - When its output is 1, counts[i] += net_dout[i] for every i.
  - Exactly L samples are taken per pass.
  - Count width is LEN_W+1, so a count of 2^LEN_W is representable and no saturation is needed.
- LFSRs:
  - Maximal-length Fibonacci, shifting left, feedback into bit 0, taps taken from the package.
  - The all-zero state is never produced, so select value 0 is never driven.
  - A period of 2^K-1 is guaranteed.
- Argmax: largest count wins; ties go to the lowest index.
- Latency: start accepted at cycle t gives CLEAR at t+1, RUN at t+2..t+1+L, and done at t+3+L+PIPE_LAT.
- Boundary conditions:
  - start while busy: ignored, no effect.
  - abort in any non-IDLE state: next state IDLE; no done; result_valid=0; counts frozen; abort in IDLE has no effect.
  - start and abort together in IDLE: start wins.
  - reset at any time overrides everything and produces the reset values above.
  - len_cfg changes during a pass are ignored.
  - len_cfg=0 gives a single-sample pass.
  - net_dout is ignored whenever the sample-valid output is 0.

Decomposition:
- Package sc_seq_pkg holds:
  - state enum type;
  - function lfsr_taps(width) returning the tap mask for widths 3..10 (e.g. 4 -> 4'b1001, 7 -> 7'b1000001);
  - function argmax tie rule.
- One natural sub-module, sc_lfsr: parameters WIDTH and SEED; inputs clk, reset, load, en; output state. Instantiated twice.

Test Plan:
1. len_cfg=3, net_dout=4'b1111 constant, PIPE_LAT=1, start at t -> done at t+8; counts all 4; class_out=0 (tie rule); result_valid=1.
2. len_cfg=255, net_dout=4'b0100 constant -> counts {0,256,0,0} for classes 3..0 (class 2 = 256); class_out=2; done at t+260.
3. K2=4, SEED2=1, len_cfg=14 -> sel2 walks 15 distinct nonzero values, first value 1; sel1 starts at SEED1; net_reset high in exactly one cycle (t+1).
4. Start pulsed again mid-RUN -> no restart, done timing unchanged. Abort at RUN cycle 3 -> IDLE next cycle, no done, result_valid=0; a new start afterwards completes normally.
5. Reset asserted mid-DRAIN -> all outputs at reset values next cycle; no done pulse.
6. net_dout driven by a model with classes 0..3 firing on 10/30/30/5 of 64 samples -> counts exact; class_out=1 (tie with class 2 goes to lowest index).
